// File: rtl/ctrl_req_sequencer.sv
// Control request sequencer: latches flush/irq/dbg pulses and
// issues them one at a time to the controller, DBG > IRQ > FLUSH.
module ctrl_req_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_req_i,
  input  logic       irq_req_i,
  input  logic       dbg_req_i,
  input  logic       ack_i,
  input  logic       done_i,
  output logic       req_valid_o,
  output logic [1:0] req_kind_o,
  output logic [2:0] pending_o,
  output logic       busy_o,
  output logic       timeout_o,
  output logic [7:0] taken_cnt_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LIM = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [1:0] K_NONE  = 2'b00;
  localparam logic [1:0] K_FLUSH = 2'b01;
  localparam logic [1:0] K_IRQ   = 2'b10;
  localparam logic [1:0] K_DBG   = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [1:0]    kind_q, kind_d;
  logic [2:0]    pend_q, pend_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          tpulse_q, tpulse_d;

  logic [1:0] pick_kind;
  logic [2:0] kind_oh;
  logic [2:0] req_set;
  logic       acked;

  assign req_set = {dbg_req_i, irq_req_i, flush_req_i};
  assign acked   = (state_q == S_ISSUE) && ack_i;

  // Highest-priority pending kind: DBG, then IRQ, then FLUSH.
  always_comb begin
    pick_kind = K_NONE;
    if (pend_q[2])      pick_kind = K_DBG;
    else if (pend_q[1]) pick_kind = K_IRQ;
    else if (pend_q[0]) pick_kind = K_FLUSH;
  end

  // One-hot pending bit belonging to the latched kind.
  always_comb begin
    kind_oh = 3'b000;
    unique case (kind_q)
      K_FLUSH: kind_oh = 3'b001;
      K_IRQ:   kind_oh = 3'b010;
      K_DBG:   kind_oh = 3'b100;
      default: kind_oh = 3'b000;
    endcase
  end

  // Sticky pending bits; a new pulse beats a same-cycle clear.
  always_comb begin
    pend_d = pend_q;
    if (acked) pend_d = pend_d & ~kind_oh;
    pend_d = pend_d | req_set;
  end

  // Wrapping count of acknowledged requests.
  always_comb begin
    cnt_d = cnt_q;
    if (acked) cnt_d = cnt_q + 8'd1;
  end

  // Sequencer FSM with ISSUE timeout; ack beats the timeout limit.
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    tmo_d    = tmo_q;
    tpulse_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pend_q != 3'b000) begin
          state_d = S_ISSUE;
          kind_d  = pick_kind;
          tmo_d   = '0;
        end
      end
      S_ISSUE: begin
        if (ack_i) begin
          state_d = S_WAIT;
        end else if (tmo_q == TMO_LIM) begin
          state_d  = S_IDLE;
          kind_d   = K_NONE;
          tpulse_d = 1'b1;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (done_i) begin
          state_d = S_IDLE;
          kind_d  = K_NONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        kind_d  = K_NONE;
      end
    endcase
  end

  // State registers; reset discards coincident request pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      kind_q   <= K_NONE;
      pend_q   <= 3'b000;
      cnt_q    <= 8'd0;
      tmo_q    <= '0;
      tpulse_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      tpulse_q <= tpulse_d;
    end
  end

  assign req_valid_o = (state_q == S_ISSUE);
  assign busy_o      = (state_q != S_IDLE);
  assign req_kind_o  = kind_q;
  assign pending_o   = pend_q;
  assign timeout_o   = tpulse_q;
  assign taken_cnt_o = cnt_q;

endmodule

// File: tb/tb_ctrl_req_sequencer.sv
// Vector-table bench for ctrl_req_sequencer with TIMEOUT = 4;
// each driven cycle queues the outputs expected after its edge.
module tb_ctrl_req_sequencer;

  logic       clk = 1'b0;
  logic       rst, fl, irq, dbg, ack, done;
  logic       req_valid_o;
  logic [1:0] req_kind_o;
  logic [2:0] pending_o;
  logic       busy_o;
  logic       timeout_o;
  logic [7:0] taken_cnt_o;

  always #5 clk = ~clk;

  ctrl_req_sequencer #(.TIMEOUT(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_req_i (fl),
    .irq_req_i   (irq),
    .dbg_req_i   (dbg),
    .ack_i       (ack),
    .done_i      (done),
    .req_valid_o (req_valid_o),
    .req_kind_o  (req_kind_o),
    .pending_o   (pending_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o),
    .taken_cnt_o (taken_cnt_o)
  );

  typedef struct {
    string       nm;
    logic [5:0]  in;
    logic [15:0] ex;
  } vec_t;

  localparam logic [5:0] I_NO  = 6'b000000;
  localparam logic [5:0] I_RST = 6'b100000;
  localparam logic [5:0] I_FL  = 6'b010000;
  localparam logic [5:0] I_IRQ = 6'b001000;
  localparam logic [5:0] I_DBG = 6'b000100;
  localparam logic [5:0] I_ACK = 6'b000010;
  localparam logic [5:0] I_DON = 6'b000001;

  vec_t vecs[$];
  vec_t exp_q[$];
  vec_t e;
  logic [15:0] got;
  int errors = 0;
  int checks = 0;

  function automatic logic [15:0] ex(
    input logic v, input logic [1:0] k, input logic [2:0] p,
    input logic b, input logic t, input logic [7:0] c);
    return {v, k, p, b, t, c};
  endfunction

  function automatic logic [15:0] idl(
    input logic [2:0] p, input logic [7:0] c);
    return ex(1'b0, 2'b00, p, 1'b0, 1'b0, c);
  endfunction

  function automatic logic [15:0] iss(
    input logic [1:0] k, input logic [2:0] p, input logic [7:0] c);
    return ex(1'b1, k, p, 1'b1, 1'b0, c);
  endfunction

  function automatic logic [15:0] wtd(
    input logic [1:0] k, input logic [2:0] p, input logic [7:0] c);
    return ex(1'b0, k, p, 1'b1, 1'b0, c);
  endfunction

  function automatic void add(
    input string nm, input logic [5:0] in, input logic [15:0] x);
    vec_t v;
    v.nm = nm;
    v.in = in;
    v.ex = x;
    vecs.push_back(v);
  endfunction

  // Monitor: compare DUT outputs after each edge against the queue.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {req_valid_o, req_kind_o, pending_o,
             busy_o, timeout_o, taken_cnt_o};
      checks++;
      if (got !== e.ex) begin
        errors++;
        $display("FAIL %s: got v=%0b k=%02b p=%03b b=%0b t=%0b c=%0d want v=%0b k=%02b p=%03b b=%0b t=%0b c=%0d",
          e.nm, got[15], got[14:13], got[12:10], got[9], got[8],
          got[7:0], e.ex[15], e.ex[14:13], e.ex[12:10], e.ex[9],
          e.ex[8], e.ex[7:0]);
      end
    end
  end

  initial begin
    logic [7:0] c;
    {rst, fl, irq, dbg, ack, done} = I_RST;

    add("rst",      I_RST,         idl(3'b000, 8'd0));
    add("rst_irq",  I_RST | I_IRQ, idl(3'b000, 8'd0));

    add("a_idle",   I_NO,  idl(3'b000, 8'd0));
    add("a_pulse",  I_IRQ, idl(3'b010, 8'd0));
    add("a_iss1",   I_NO,  iss(2'b10, 3'b010, 8'd0));
    add("a_iss2",   I_NO,  iss(2'b10, 3'b010, 8'd0));
    add("a_iss3",   I_NO,  iss(2'b10, 3'b010, 8'd0));
    add("a_ack",    I_ACK, wtd(2'b10, 3'b000, 8'd1));
    add("a_wait",   I_NO,  wtd(2'b10, 3'b000, 8'd1));
    add("a_done",   I_DON, idl(3'b000, 8'd1));
    add("a_idle2",  I_NO,  idl(3'b000, 8'd1));
    add("a_ign",    I_ACK | I_DON, idl(3'b000, 8'd1));

    add("b_rst",    I_RST, idl(3'b000, 8'd0));
    add("b_pulse",  I_FL | I_IRQ | I_DBG, idl(3'b111, 8'd0));
    add("b_iss_d",  I_NO,  iss(2'b11, 3'b111, 8'd0));
    add("b_ack_d",  I_ACK, wtd(2'b11, 3'b011, 8'd1));
    add("b_done_d", I_DON, idl(3'b011, 8'd1));
    add("b_iss_i",  I_NO,  iss(2'b10, 3'b011, 8'd1));
    add("b_ack_i",  I_ACK, wtd(2'b10, 3'b001, 8'd2));
    add("b_done_i", I_DON | I_ACK, idl(3'b001, 8'd2));
    add("b_iss_f",  I_NO,  iss(2'b01, 3'b001, 8'd2));
    add("b_ack_f",  I_ACK, wtd(2'b01, 3'b000, 8'd3));
    add("b_done_f", I_DON, idl(3'b000, 8'd3));

    add("c_pulse",  I_FL,  idl(3'b001, 8'd3));
    add("c_iss1",   I_NO,  iss(2'b01, 3'b001, 8'd3));
    add("c_iss2",   I_NO,  iss(2'b01, 3'b001, 8'd3));
    add("c_dbg",    I_DBG, iss(2'b01, 3'b101, 8'd3));
    add("c_ack",    I_ACK, wtd(2'b01, 3'b100, 8'd4));
    add("c_done",   I_DON, idl(3'b100, 8'd4));
    add("c_iss_d",  I_NO,  iss(2'b11, 3'b100, 8'd4));
    add("c_ack_d",  I_ACK, wtd(2'b11, 3'b000, 8'd5));
    add("c_rst",    I_RST, idl(3'b000, 8'd0));
    add("c_late",   I_DON, idl(3'b000, 8'd0));

    add("d_pulse",  I_IRQ, idl(3'b010, 8'd0));
    add("d_iss1",   I_NO,  iss(2'b10, 3'b010, 8'd0));
    add("d_iss2",   I_NO,  iss(2'b10, 3'b010, 8'd0));
    add("d_iss3",   I_NO,  iss(2'b10, 3'b010, 8'd0));
    add("d_iss4",   I_NO,  iss(2'b10, 3'b010, 8'd0));
    add("d_tmo",    I_NO,  ex(1'b0, 2'b00, 3'b010, 1'b0, 1'b1, 8'd0));
    add("d_retry",  I_NO,  iss(2'b10, 3'b010, 8'd0));
    add("d_r2",     I_NO,  iss(2'b10, 3'b010, 8'd0));
    add("d_r3",     I_NO,  iss(2'b10, 3'b010, 8'd0));
    add("d_r4",     I_NO,  iss(2'b10, 3'b010, 8'd0));
    add("d_ack_lim", I_ACK, wtd(2'b10, 3'b000, 8'd1));
    add("d_done",   I_DON, idl(3'b000, 8'd1));

    add("e_pulse",  I_FL,  idl(3'b001, 8'd1));
    add("e_iss",    I_NO,  iss(2'b01, 3'b001, 8'd1));
    add("e_rst",    I_RST | I_ACK, idl(3'b000, 8'd0));

    for (int k = 0; k < 255; k++) begin
      c = 8'(k);
      add("w_pulse", I_IRQ, idl(3'b010, c));
      add("w_iss",   I_NO,  iss(2'b10, 3'b010, c));
      c = 8'(k + 1);
      add("w_ack",   I_ACK, wtd(2'b10, 3'b000, c));
      add("w_done",  I_DON, idl(3'b000, c));
    end
    add("w_pulse_l", I_IRQ, idl(3'b010, 8'd255));
    add("w_iss_l",   I_NO,  iss(2'b10, 3'b010, 8'd255));
    add("w_ack_set", I_ACK | I_IRQ, wtd(2'b10, 3'b010, 8'd0));
    add("w_done_l",  I_DON, idl(3'b010, 8'd0));
    add("w_reiss",   I_NO,  iss(2'b10, 3'b010, 8'd0));
    add("w_ack2",    I_ACK, wtd(2'b10, 3'b000, 8'd1));
    add("w_done2",   I_DON, idl(3'b000, 8'd1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      {rst, fl, irq, dbg, ack, done} = vecs[i].in;
      exp_q.push_back(vecs[i]);
    end
    @(negedge clk);
    {rst, fl, irq, dbg, ack, done} = I_NO;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d queued, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_req_sequencer.md
CTRL_REQ_SEQUENCER -- requirements
Module: ctrl_req_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 16: the maximum number of cycles spent in ISSUE without ack_i before the request is abandoned.
REQ-002 clk_i  in  1  clock; all logic SHALL be rising-edge triggered.
REQ-003 rst_i  in  1  reset; synchronous, active-high.
REQ-004 flush_req_i  in  1  one-cycle flush request pulse.
REQ-005 irq_req_i  in  1  one-cycle interrupt request pulse.
REQ-006 dbg_req_i  in  1  one-cycle debug request pulse.
REQ-007 ack_i  in  1  controller has left DECODE into the taken state for the issued kind.
REQ-008 done_i  in  1  controller has returned to DECODE.
REQ-009 req_valid_o  out  1  request is presented to the controller.
REQ-010 req_kind_o  out  2  kind of the request: 00 none, 01 FLUSH, 10 IRQ, 11 DBG.
REQ-011 pending_o  out  3  sticky pending bits, ordered {dbg, irq, flush}.
REQ-012 busy_o  out  1  FSM is not in IDLE.
REQ-013 timeout_o  out  1  one-cycle pulse when an issued request is abandoned.
REQ-014 taken_cnt_o  out  8  wrapping count of acknowledged requests.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT_DONE.
REQ-016 A request pulse SHALL set its pending bit on the next edge, and pending_o SHALL reflect the new value one cycle after the pulse.
REQ-017 If a request pulse and the clear (from ack) of the same pending bit occur in the same cycle, the set SHALL win and the bit SHALL stay 1.
REQ-018 IDLE -> ISSUE SHALL occur when pending_o != 0.
- On that edge the highest-priority pending kind SHALL be latched into req_kind_o.
- Priority order is DBG > IRQ > FLUSH.
REQ-019 In ISSUE, req_valid_o SHALL be 1, and req_kind_o SHALL stay stable until the state is left (no preemption by later higher-priority requests).
REQ-020 When ack_i = 1 in ISSUE:
- the latched kind's pending bit SHALL clear;
- taken_cnt_o SHALL increment by 1, wrapping from 255 to 0;
- the FSM SHALL go to WAIT_DONE.
REQ-021 In WAIT_DONE, req_valid_o SHALL be 0, and done_i = 1 SHALL return the FSM to IDLE on the next edge.
REQ-022 The earliest re-issue after WAIT_DONE -> IDLE SHALL be one cycle later (IDLE is always occupied at least one cycle).
REQ-023 Timeout counter:
- cleared on ISSUE entry, increments every ISSUE cycle without ack_i;
- when it reaches TIMEOUT-1 without ack_i, timeout_o SHALL pulse for one cycle and the FSM SHALL go to IDLE;
- the pending bit SHALL be retained so the request retries;
- counter width SHALL be $clog2(TIMEOUT+1).
REQ-024 If ack_i arrives in the same cycle as the timeout limit, ack SHALL take precedence and timeout_o SHALL stay 0.
REQ-025 ack_i or done_i outside ISSUE or WAIT_DONE respectively SHALL be ignored, with no state, count or pending change.
REQ-026 req_kind_o SHALL be 00 whenever the FSM is in IDLE, and SHALL hold the latched kind in ISSUE and WAIT_DONE.
REQ-027 busy_o SHALL be 1 in ISSUE and WAIT_DONE, and 0 in IDLE.

Reset
REQ-028 While rst_i = 1 at a clock edge, the block SHALL enter, and remain in, the following state:
- FSM in IDLE;
- pending_o = 000;
- req_valid_o = 0, req_kind_o = 00, busy_o = 0, timeout_o = 0;
- taken_cnt_o = 0;
- timeout counter = 0.
REQ-029 Request pulses coincident with rst_i = 1 SHALL be discarded.
REQ-030 Reset asserted mid-ISSUE or mid-WAIT_DONE SHALL abort the transaction on that edge, with no timeout_o pulse and no count change.

Verification
REQ-031 irq_req_i pulse at cycle 0, ack_i at cycle 4, done_i at cycle 6:
- cycle 1: pending_o = 010;
- cycles 2-4: req_valid_o = 1, req_kind_o = 10;
- cycle 5: pending_o = 000, taken_cnt_o = 1;
- cycle 7: IDLE.
REQ-032 flush, irq and dbg pulses in the same cycle, acked and done each time:
- issue order SHALL be DBG (11), IRQ (10), FLUSH (01);
- taken_cnt_o SHALL end at 3.
REQ-033 flush pulse, then a dbg pulse 2 cycles into ISSUE:
- req_kind_o SHALL stay 01 until ack_i;
- DBG SHALL be issued next.
REQ-034 TIMEOUT = 4, irq pending, ack_i never asserted:
- timeout_o SHALL pulse after 4 ISSUE cycles;
- the FSM SHALL return to IDLE, then re-enter ISSUE with pending_o = 010 retained.
REQ-035 rst_i = 1 during WAIT_DONE with taken_cnt_o = 5:
- next cycle: all outputs at reset values, taken_cnt_o = 0;
- a late done_i SHALL be ignored.
REQ-036 256 acknowledged requests: taken_cnt_o SHALL wrap to 0; the same-cycle irq pulse plus IRQ ack case SHALL leave pending_o[1] = 1.
